// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit ripple slice reused over NIBBLES cycles,
// LSB nibble first. The result is published only once the whole sum is complete.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   opA,
    input  logic [4*NIBBLES-1:0]   opB,
    input  logic                   carryIn,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carryOut
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic          cy_q, cy_d, co_q, co_d;
    logic [4:0]    slice;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        co_d    = co_q;
        slice   = {1'b0, a_q[idx_q*4 +: 4]} + {1'b0, b_q[idx_q*4 +: 4]} + {4'b0000, cy_q};
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = opA;
                    b_d     = opB;
                    cy_d    = carryIn;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q*4 +: 4] = slice[3:0];
                cy_d                = slice[4];
                if (idx_q == LAST) begin
                    // res_d already carries the final nibble written above
                    sum_d   = res_d;
                    co_d    = slice[4];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign carryOut = co_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder against plain 17-bit addition.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [15:0] opA, opB;
    logic        carryIn;
    logic        busy, done;
    logic [15:0] sum;
    logic        carryOut;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rstN(rstN), .start(start), .opA(opA), .opB(opB),
        .carryIn(carryIn), .busy(busy), .done(done), .sum(sum), .carryOut(carryOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full addition; optionally pokes a second start mid-RUN.
    task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input bit second, input string tag);
        logic [16:0] exp;
        logic [15:0] prev;
        int cycles, busy_cnt;
        exp  = {1'b0, a} + {1'b0, b} + {16'd0, c};
        prev = sum;
        opA = a; opB = b; carryIn = c; start = 1'b1;
        tick();
        start = 1'b0;
        opA = 16'($urandom); opB = 16'($urandom); carryIn = 1'($urandom);
        cycles = 0; busy_cnt = 0;
        while (!done && cycles < 20) begin
            chk({tag, "_hold"}, sum, prev);
            if (busy) busy_cnt++;
            start = (second && cycles == 1);
            if (second && cycles == 1) begin
                opA = 16'h0F0F; opB = 16'h1357; carryIn = 1'b1;
            end
            tick();
            start = 1'b0;
            cycles++;
        end
        if (busy) busy_cnt++;
        chk({tag, "_latency"}, cycles, 4);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_sum"}, sum, exp[15:0]);
        chk({tag, "_cout"}, carryOut, exp[16]);
        chk({tag, "_busycnt"}, busy_cnt, 5);
        tick();
        chk({tag, "_done_low"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_sum_held"}, sum, exp[15:0]);
    endtask

    initial begin
        logic [16:0] ref_sum;
        int last_done, npulse, t;
        rstN = 1'b0; start = 1'b0; opA = '0; opB = '0; carryIn = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", carryOut, 0);
        tick(); tick();
        rstN = 1'b1;
        tick();

        run_add(16'h0000, 16'h0000, 1'b1, 1'b0, "zero_cin");
        run_add(16'h1234, 16'h4321, 1'b1, 1'b0, "basic");
        run_add(16'hA5C3, 16'h5A3C, 1'b1, 1'b0, "ripple_full");
        run_add(16'hA5C3, 16'h5A3C, 1'b0, 1'b0, "ripple_none");
        run_add(16'hFFFF, 16'h0001, 1'b0, 1'b1, "ignore_start");
        run_add(16'hFFFF, 16'h0000, 1'b1, 1'b0, "ripple_ffff");

        // Abort mid-RUN: outputs clear asynchronously and no done follows.
        opA = 16'h1111; opB = 16'h2222; carryIn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rstN = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", carryOut, 0);
        start = 1'b1;
        tick(); tick();
        chk("rst_start_ignored", busy, 0);
        start = 1'b0;
        rstN = 1'b1;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) npulse++;
        end
        chk("abort_no_done", npulse, 0);
        run_add(16'h0003, 16'h0004, 1'b0, 1'b0, "after_abort");

        // Continuous start: one addition every 6 cycles, same result each time.
        opA = 16'hBEEF; opB = 16'h4111; carryIn = 1'b1;
        ref_sum = {1'b0, opA} + {1'b0, opB} + 17'd1;
        start = 1'b1;
        npulse = 0; last_done = -1;
        for (t = 1; t <= 20; t++) begin
            tick();
            if (done) begin
                npulse++;
                chk("cont_sum", sum, ref_sum[15:0]);
                chk("cont_cout", carryOut, ref_sum[16]);
                if (last_done >= 0) chk("cont_period", t - last_done, 6);
                last_done = t;
            end
        end
        start = 1'b0;
        chk("cont_pulses", npulse, 3);
        for (int i = 0; i < 8; i++) tick();

        for (int i = 0; i < 10; i++)
            run_add(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
